// File: rtl/bitreverse_pkg.sv
// Shared definitions for the variable-size FFT bit-reversal buffer.
// Holds default parameter values, the frame-size clamp and the
// variable-width bit-reverse index helper.
package bitreverse_pkg;

    localparam int LGMAX_DEF = 10;
    localparam int LGMIN_DEF = 2;
    localparam int WIDTH_DEF = 16;
    localparam int LGSIZE_W  = $clog2(LGMAX_DEF + 1);

    // Clamp a requested log2 frame size into [lgmin, lgmax].
    function automatic int unsigned clamp_lgsize(input int unsigned lg,
                                                 input int unsigned lgmin,
                                                 input int unsigned lgmax);
        if (lg < lgmin) return lgmin;
        if (lg > lgmax) return lgmax;
        return lg;
    endfunction

    // Reverse the low lgmax bits of idx, then shift right so the result is
    // the reversal over the low lgsize bits with the unused upper bits zero.
    function automatic logic [31:0] bitrev_var(input logic [31:0] idx,
                                               input int unsigned lgsize,
                                               input int unsigned lgmax);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(lgmax))
                r[5'(i)] = idx[5'(int'(lgmax) - 1 - i)];
        end
        return r >> (lgmax - lgsize);
    endfunction

endpackage

// File: rtl/bitreverse_var_dpram.sv
// Simple dual-port frame buffer: one write port, one registered read port,
// both advancing on the shared sample enable. The read register is the
// block's output register, so it carries the synchronous reset.
module bitrev_dpram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_data_q;

    // Write port; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (i_ce)
            mem[i_wr_addr] <= i_wr_data;
    end

    // Registered read port, sees the pre-write contents.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            rd_data_q <= '0;
        else if (i_ce)
            rd_data_q <= mem[i_rd_addr];
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/bitreverse_var.sv
// Variable-size pipelined FFT bit-reversal buffer with sync realignment.
// One bank is written in natural order while the other bank (the previous
// frame) is read out in bit-reversed order.
// Build option: define BITREVERSE_BYPASS_EN to honour i_bypass (natural-order
// readout selected per frame); otherwise output is always bit-reversed.
module bitreverse_var
    import bitreverse_pkg::*;
#(
    parameter int LGMAX = LGMAX_DEF,
    parameter int LGMIN = LGMIN_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_ce,
    input  logic                       i_sync,
    input  logic [$clog2(LGMAX+1)-1:0] i_lgsize,
    input  logic                       i_bypass,
    input  logic [2*WIDTH-1:0]         i_in,
    output logic [2*WIDTH-1:0]         o_out,
    output logic                       o_sync,
    output logic                       o_err
);

    localparam int LG_W = $clog2(LGMAX + 1);

    typedef logic [LGMAX-1:0] idx_t;
    typedef logic [LG_W-1:0]  lg_t;

    idx_t wr_idx_q, wr_idx_d;
    logic wr_bank_q;
    logic primed_q;
    lg_t  wr_lg_q, rd_lg_q;
    logic sync_q, err_q;

    logic resync, frame_start, wrap;
    lg_t  eff_lg, cur_lg;
    idx_t w_idx, last_idx, rd_rev, rd_idx;
    logic cur_byp, rd_byp;

    assign resync      = i_sync && (wr_idx_q != '0);
    assign frame_start = (wr_idx_q == '0) || resync;
    assign eff_lg      = lg_t'(clamp_lgsize(32'(i_lgsize), 32'(LGMIN), 32'(LGMAX)));
    assign cur_lg      = frame_start ? eff_lg : wr_lg_q;

    // A resync sample lands at index 0 of the current bank.
    assign w_idx    = resync ? '0 : wr_idx_q;
    assign last_idx = idx_t'((32'd1 << cur_lg) - 32'd1);
    assign wrap     = (w_idx == last_idx);
    assign wr_idx_d = wrap ? '0 : w_idx + idx_t'(1);

    // The read side follows the raw write counter so a resync cycle does not
    // disturb the outgoing frame's addressing.
    assign rd_rev = idx_t'(bitrev_var(32'(wr_idx_q), 32'(rd_lg_q), 32'(LGMAX)));

`ifdef BITREVERSE_BYPASS_EN
    logic wr_byp_q, rd_byp_q;

    assign cur_byp = frame_start ? i_bypass : wr_byp_q;
    assign rd_byp  = rd_byp_q;
    assign rd_idx  = rd_byp ? wr_idx_q : rd_rev;

    // Per-frame bypass selection, latched at frame start and handed to the
    // read side at the frame boundary.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_byp_q <= 1'b0;
            rd_byp_q <= 1'b0;
        end else if (i_ce) begin
            if (frame_start)
                wr_byp_q <= i_bypass;
            if (wrap)
                rd_byp_q <= cur_byp;
        end
    end
`else
    logic unused_bypass;

    assign unused_bypass = i_bypass;
    assign cur_byp       = 1'b0;
    assign rd_byp        = 1'b0;
    assign rd_idx        = rd_rev;
`endif

    // Write framing, bank swap, size hand-off and status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            primed_q  <= 1'b0;
            wr_lg_q   <= lg_t'(LGMAX);
            rd_lg_q   <= lg_t'(LGMAX);
            sync_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (i_ce) begin
            wr_idx_q <= wr_idx_d;
            if (frame_start)
                wr_lg_q <= eff_lg;
            if (wrap) begin
                wr_bank_q <= ~wr_bank_q;
                rd_lg_q   <= cur_lg;
                primed_q  <= 1'b1;
            end
            if (resync)
                primed_q <= 1'b0;
            sync_q <= primed_q && (wr_idx_q == '0);
            err_q  <= resync;
        end else begin
            err_q <= 1'b0;
        end
    end

    bitrev_dpram #(
        .AW(LGMAX + 1),
        .DW(2 * WIDTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_ce      (i_ce),
        .i_wr_addr ({wr_bank_q, w_idx}),
        .i_wr_data (i_in),
        .i_rd_addr ({~wr_bank_q, rd_idx}),
        .o_rd_data (o_out)
    );

    assign o_sync = sync_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_bitreverse_var.sv
// Self-checking bench for bitreverse_var (LGMAX=4). A frame-level model
// predicts outputs every cycle; directed literal checks pin the model.
// Honours BITREVERSE_BYPASS_EN the same way the design does.
module tb_bitreverse_var;

    localparam int LGMAX = 4;
    localparam int LGMIN = 2;
    localparam int WIDTH = 16;
    localparam int N     = 1 << LGMAX;
`ifdef BITREVERSE_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ce, sync, byp;
    logic [2:0]  lg;
    logic [31:0] din;
    logic [31:0] dout;
    logic        osync, oerr;

    always #5 clk = ~clk;

    bitreverse_var #(.LGMAX(LGMAX), .LGMIN(LGMIN), .WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_ce     (ce),
        .i_sync   (sync),
        .i_lgsize (lg),
        .i_bypass (byp),
        .i_in     (din),
        .o_out    (dout),
        .o_sync   (osync),
        .o_err    (oerr)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [31:0] prev_d [N];
    logic [31:0] cur_d  [N];
    int  prev_lg, cur_lg, m_idx;
    bit  prev_byp, cur_byp, prev_valid;
    logic [31:0] exp_out;
    bit  exp_sync, exp_err, out_known;

    function automatic int rev(input int j, input int n);
        int r = 0;
        for (int b = 0; b < n; b++) r = (r << 1) | ((j >> b) & 1);
        return r;
    endfunction

    function automatic int clampl(input int v);
        if (v < LGMIN) return LGMIN;
        if (v > LGMAX) return LGMAX;
        return v;
    endfunction

    task automatic model_update();
        bit rs;
        int j;
        if (rst) begin
            m_idx = 0; prev_valid = 0; prev_lg = LGMAX; prev_byp = 0;
            cur_lg = LGMAX; cur_byp = 0;
            exp_out = 0; out_known = 1; exp_sync = 0; exp_err = 0;
        end else if (!ce) begin
            exp_err = 0;
        end else begin
            rs = sync && (m_idx != 0);
            j  = m_idx;
            exp_sync = prev_valid && (j == 0);
            exp_err  = rs;
            if (prev_valid && !rs && j < (1 << prev_lg)) begin
                out_known = 1;
                exp_out = prev_byp ? prev_d[j] : prev_d[rev(j, prev_lg)];
            end else begin
                out_known = 0;
            end
            if (j == 0 || rs) begin
                cur_lg  = clampl(int'(lg));
                cur_byp = BYP_EN && byp;
                j = 0;
            end
            cur_d[j] = din;
            j++;
            if (rs) prev_valid = 0;
            if (j == (1 << cur_lg)) begin
                prev_d = cur_d; prev_lg = cur_lg; prev_byp = cur_byp;
                prev_valid = 1; m_idx = 0;
            end else begin
                m_idx = j;
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("o_sync", 32'(osync), 32'(exp_sync));
            check("o_err",  32'(oerr),  32'(exp_err));
            if (out_known) check("o_out", dout, exp_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic c, input logic s, input logic [2:0] l,
                        input logic b, input logic [31:0] d, input logic r);
        @(negedge clk);
        ce = c; sync = s; lg = l; byp = b; din = d; rst = r;
        @(posedge clk);
        model_update();
    endtask

    task automatic frame(input logic [2:0] l, input logic b, input int base,
                         input int n, input logic s0);
        for (int j = 0; j < n; j++) step(1'b1, s0 && (j == 0), l, b, 32'(base + j), 1'b0);
    endtask

    int lit1 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int lit2 [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [31:0] hold_out;
    logic        hold_sync;
    int first;

    initial begin
        rst = 1; ce = 0; sync = 0; lg = 3'd4; byp = 0; din = 0;
        step(1'b0, 1'b0, 3'd4, 1'b0, 32'd0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 3'd4, 1'b0, 32'd0, 1'b1);
        #1;
        check("rst_out", dout, 32'd0);
        check("rst_sync", 32'(osync), 32'd0);
        check("rst_err", 32'(oerr), 32'd0);

        // 1: two 16-sample frames, second interval shows bit-reversed order
        frame(3'd4, 1'b0, 0, 16, 1'b0);
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 1'b0, 3'd4, 1'b0, 32'(j), 1'b0);
            #1;
            check("t1_out", dout, 32'(lit1[j]));
            check("t1_sync", 32'(osync), 32'(j == 0));
        end

        // 2: shrink to 8: old frame truncated, then 8-point reversal
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 3'd3, 1'b0, 32'(100 + j), 1'b0);
            #1;
            check("t2_trunc", dout, 32'(lit1[j]));
        end
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 3'd3, 1'b0, 32'(150 + j), 1'b0);
            #1;
            check("t2_out", dout, 32'(100 + lit2[j]));
            check("t2_sync", 32'(osync), 32'(j == 0));
        end

        // 3: bypass requested at frame start
        frame(3'd4, 1'b1, 300, 16, 1'b0);
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 1'b0, 3'd4, 1'b0, 32'(400 + j), 1'b0);
            #1;
            check("t3_out", dout, 32'(300 + (BYP_EN ? j : lit1[j])));
        end

        // 4: sync at wr_idx=5 -> error pulse, o_sync suppressed, realigned
        frame(3'd4, 1'b0, 500, 5, 1'b0);
        step(1'b1, 1'b1, 3'd4, 1'b0, 32'd600, 1'b0);
        #1;
        check("t4_err_pulse", 32'(oerr), 32'd1);
        check("t4_sync_off", 32'(osync), 32'd0);
        for (int k = 1; k < 16; k++) begin
            step(1'b1, 1'b0, 3'd4, 1'b0, 32'(600 + k), 1'b0);
            #1;
            if (k == 1) check("t4_err_clear", 32'(oerr), 32'd0);
            check("t4_sync_off", 32'(osync), 32'd0);
        end
        for (int j = 0; j < 16; j++) begin
            step(1'b1, j == 0, 3'd4, 1'b0, 32'(700 + j), 1'b0);
            #1;
            check("t4_out", dout, 32'(600 + lit1[j]));
            check("t4_sync", 32'(osync), 32'(j == 0));
        end

        // 5: i_ce pattern 1,0,0 with outputs held while disabled
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 1'b0, 3'd4, 1'b0, 32'(800 + j), 1'b0);
            repeat (2) step(1'b0, 1'b0, 3'd4, 1'b0, 32'hdead, 1'b0);
        end
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 1'b0, 3'd4, 1'b0, 32'(900 + j), 1'b0);
            #1;
            hold_out  = dout;
            hold_sync = osync;
            check("t5_out", dout, 32'(800 + lit1[j]));
            check("t5_sync", 32'(osync), 32'(j == 0));
            for (int h = 0; h < 2; h++) begin
                step(1'b0, 1'b1, 3'd2, 1'b1, 32'hbeef, 1'b0);
                #1;
                check("t5_hold_out", dout, hold_out);
                check("t5_hold_sync", 32'(osync), 32'(hold_sync));
            end
        end

        // 6: reset at wr_idx=9, first o_sync 16 enables after release
        frame(3'd4, 1'b0, 1000, 9, 1'b0);
        step(1'b1, 1'b0, 3'd4, 1'b0, 32'd1, 1'b1);
        #1;
        check("t6_rst_out", dout, 32'd0);
        check("t6_rst_sync", 32'(osync), 32'd0);
        check("t6_rst_err", 32'(oerr), 32'd0);
        first = -1;
        for (int s = 0; s < 40 && first < 0; s++) begin
            step(1'b1, 1'b0, 3'd7, 1'b0, 32'(2000 + s), 1'b0);
            #1;
            if (osync) first = s;
        end
        check("t6_first_sync", 32'(first), 32'd16);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
